// File: rtl/mult_sequencer_if.sv
// Handshake between the sequencer and the iterative multiplier.
// The sequencer is the master: it launches work and supplies signedness.
// The multiplier is the slave: it reports readiness and returns the product.
interface mult_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start_mult;
  logic               mult_sign;
  logic               mult_ready;
  logic               mult_done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start_mult,
    output mult_sign,
    input  mult_ready,
    input  mult_done,
    input  product
  );

  modport slave (
    input  start_mult,
    input  mult_sign,
    output mult_ready,
    output mult_done,
    output product
  );
endinterface

// File: rtl/mult_sequencer.sv
// Multiply sequencer for the execute stage.
// It launches the shared iterative multiplier for mult/multu, holds HI/LO,
// and raises a stall for mfhi/mflo/mult in decode while a multiply is pending.
// A watchdog aborts a multiply that never completes and sets a sticky error.
module mult_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_d,
  input  logic             mult_sign_d,
  input  logic             mfhi_d,
  input  logic             mflo_d,
  input  logic             stall_d,
  input  logic             flush_e,
  mult_sequencer_if.master mif,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             mult_stall,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_err;

  logic               w_pending;
  logic               w_stall;
  logic               w_issue;
  logic               w_done_busy;
  logic               w_timeout;
  logic               w_start;
  logic               w_busy;

  // A multiply is still outstanding unless its product arrives this cycle.
  assign w_pending   = (r_state == S_START) ||
                       ((r_state == S_BUSY) && !mif.mult_done);
  assign w_stall     = (mfhi_d || mflo_d || mult_d) && w_pending;
  assign w_issue     = mult_d && !stall_d && !flush_e && !w_stall;
  assign w_done_busy = (r_state == S_BUSY) && mif.mult_done;
  assign w_timeout   = (r_state == S_BUSY) && !mif.mult_done &&
                       (r_cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_next = S_START;
      S_START: if (mif.mult_ready) w_next = S_BUSY;
      S_BUSY: begin
        // A mult issuing in the done cycle is in execute on the next cycle,
        // so it goes straight to START rather than through an IDLE cycle
        // in which its operands would already have moved on.
        if (mif.mult_done) begin
          w_next = w_issue ? S_START : S_IDLE;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    w_start = (r_state == S_START) && mif.mult_ready;
    w_busy  = (r_state != S_IDLE);
  end

  // Signedness capture, watchdog counter, HI/LO and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sign <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_issue) begin
        r_sign <= mult_sign_d;
      end
      if ((r_state == S_BUSY) && !mif.mult_done && !w_timeout) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (w_done_busy) begin
        r_hi <= mif.product[2*WIDTH-1:WIDTH];
        r_lo <= mif.product[WIDTH-1:0];
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign mif.start_mult = w_start;
  assign mif.mult_sign  = r_sign;
  assign hi_out         = r_hi;
  assign lo_out         = r_lo;
  assign mult_stall     = w_stall;
  assign busy           = w_busy;
  assign timeout_err    = r_err;

endmodule
